bcast_fork: RTL and testbench

- Registered one-to-many broadcast stage; the distribution counterpart of the N-to-1 reduction tree.
- Accepts one DATA-wide word per handshake on a single valid/ready input.
- Delivers the word to every output selected by a per-transaction destination mask. Each output has its own valid/ready handshake.
- Sits between a single producer and OUT independent consumers; consumers may stall independently.

---
 rtl/bcast_pkg.sv | 18 +
 rtl/bcast_lane.sv | 47 ++++
 rtl/bcast_fork.sv | 87 ++++++++
 tb/tb_bcast_fork.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/bcast_pkg.sv
// -----------------------------------------------------------------------------
// bcast_pkg
//   Shared types and constants for the bcast_fork broadcast stage.
//   - bcast_state_t : top-level FSM state (IDLE = nothing pending,
//                     BUSY = held word still owed to at least one branch)
//   - ENABLE/DISABLE: single-bit logic levels used for the pending flags
// -----------------------------------------------------------------------------
package bcast_pkg;

  typedef enum logic {
    BC_IDLE = 1'b0,
    BC_BUSY = 1'b1
  } bcast_state_t;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

endpackage : bcast_pkg

// File: rtl/bcast_lane.sv
// -----------------------------------------------------------------------------
// bcast_lane
//   One output branch of the broadcast fork. Holds the branch's pending bit,
//   which is this branch's out_valid, and reports when the branch handshakes.
//
//   Ports:
//     clk        in   clock, rising edge
//     reset_     in   asynchronous active-low reset
//     load       in   a new word is being accepted this cycle
//     load_bit   in   destination-mask bit for this branch (sampled on load)
//     out_ready  in   consumer ready for this branch
//     out_valid  out  word pending on this branch
//     done       out  branch handshake completes this cycle
// -----------------------------------------------------------------------------
module bcast_lane
  import bcast_pkg::*;
(
  input  logic clk,
  input  logic reset_,
  input  logic load,
  input  logic load_bit,
  input  logic out_ready,
  output logic out_valid,
  output logic done
);

  logic pend_q;

  // out_ready is ignored while nothing is pending.
  assign done      = pend_q & out_ready;
  assign out_valid = pend_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      pend_q <= DISABLE;
    end else if (load) begin
      // A load wins over a same-cycle completion: the old word has finished
      // (the top only loads when nothing would stall) and the new bit takes over.
      pend_q <= load_bit;
    end else if (done) begin
      pend_q <= DISABLE;
    end
  end

endmodule : bcast_lane

// File: rtl/bcast_fork.sv
// -----------------------------------------------------------------------------
// bcast_fork
//   Registered one-to-many broadcast stage. Accepts one DATA-wide word per
//   input handshake and presents it on every branch selected by in_mask;
//   each branch completes independently on its own valid/ready handshake.
//   A new word is accepted as soon as every still-pending branch is ready,
//   giving one word per cycle when consumers keep up.
//
//   Parameters:
//     OUT   number of output branches (>= 1)
//     DATA  data width in bits
//
//   Ports:
//     clk        in   clock, rising edge
//     reset_     in   asynchronous active-low reset
//     in_valid   in   input word valid
//     in_ready   out  input accepted when in_valid & in_ready
//     in_data    in   word to broadcast
//     in_mask    in   destination select, bit i = deliver to branch i
//     out_valid  out  per-branch valid
//     out_ready  in   per-branch ready
//     out_data   out  per-branch data (the same held word on every branch)
//     busy       out  a held word still has at least one delivery pending
// -----------------------------------------------------------------------------
module bcast_fork
  import bcast_pkg::*;
#(
  parameter int OUT  = 4,
  parameter int DATA = 16
) (
  input  logic                      clk,
  input  logic                      reset_,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA-1:0]           in_data,
  input  logic [OUT-1:0]            in_mask,
  output logic [OUT-1:0]            out_valid,
  input  logic [OUT-1:0]            out_ready,
  output logic [OUT-1:0][DATA-1:0]  out_data,
  output logic                      busy
);

  bcast_state_t    state_q;
  logic [DATA-1:0] data_q;
  logic [OUT-1:0]  done_v;
  logic [OUT-1:0]  pend_left;
  logic            accept;

  // Branches that would still be pending after this cycle's handshakes.
  assign pend_left = out_valid & ~done_v;

  // Combinational from out_ready so the final handshake of one word and the
  // accept of the next can share a cycle (full throughput).
  assign in_ready = (state_q == BC_IDLE) || (pend_left == '0);
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q == BC_BUSY);

  for (genvar i = 0; i < OUT; i++) begin : g_lane
    bcast_lane u_lane (
      .clk       (clk),
      .reset_    (reset_),
      .load      (accept),
      .load_bit  (in_mask[i]),
      .out_ready (out_ready[i]),
      .out_valid (out_valid[i]),
      .done      (done_v[i])
    );

    assign out_data[i] = data_q;
  end

  // NOTE: data_q is reset even though out_valid gates it, so out_data reads a
  // defined zero after reset instead of whatever the flops powered up with.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= BC_IDLE;
      data_q  <= '0;
    end else if (accept) begin
      // A zero mask still loads data_q but leaves nothing pending: word dropped.
      data_q  <= in_data;
      state_q <= (|in_mask) ? BC_BUSY : BC_IDLE;
    end else if (pend_left == '0) begin
      state_q <= BC_IDLE;
    end
  end

endmodule : bcast_fork

// File: tb/tb_bcast_fork.sv
// -----------------------------------------------------------------------------
// tb_bcast_fork
//   Self-checking bench for bcast_fork (OUT=4, DATA=16). A table of per-cycle
//   records gives the inputs driven in a cycle and the outputs expected in that
//   same cycle; hand-written sequences cover reset release and an asynchronous
//   reset in the middle of a transaction.
// -----------------------------------------------------------------------------
module tb_bcast_fork;

  localparam int OUT  = 4;
  localparam int DATA = 16;
  localparam int NVEC = 17;

  logic                     clk;
  logic                     reset_;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA-1:0]          in_data;
  logic [OUT-1:0]           in_mask;
  logic [OUT-1:0]           out_valid;
  logic [OUT-1:0]           out_ready;
  logic [OUT-1:0][DATA-1:0] out_data;
  logic                     busy;

  int n_vec;
  int n_err;

  typedef struct {
    logic            iv;
    logic [DATA-1:0] d;
    logic [OUT-1:0]  m;
    logic [OUT-1:0]  r;
    logic            e_rdy;
    logic [OUT-1:0]  e_vld;
    logic            e_busy;
    logic [DATA-1:0] e_data;
  } vec_t;

  vec_t vecs [NVEC];

  bcast_fork #(.OUT(OUT), .DATA(DATA)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_rdy, input logic [OUT-1:0] e_vld,
                            input logic e_busy, input logic [DATA-1:0] e_data);
    logic [OUT-1:0][DATA-1:0] e_all;
    for (int i = 0; i < OUT; i++) e_all[i] = e_data;
    check({tag, ".in_ready"},  64'(in_ready),  64'(e_rdy));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(e_vld));
    check({tag, ".busy"},      64'(busy),      64'(e_busy));
    check({tag, ".out_data"},  64'(out_data),  64'(e_all));
  endtask

  task automatic drive(input logic iv, input logic [DATA-1:0] d, input logic [OUT-1:0] m,
                       input logic [OUT-1:0] r);
    in_valid  = iv;
    in_data   = d;
    in_mask   = m;
    out_ready = r;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    //                iv    data       mask     ready    rdy   vld      busy  data
    // Back-to-back broadcast, all branches ready.
    vecs[0]  = '{1'b1, 16'hA5A5, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 16'hA5A6, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 16'hA5A5};
    vecs[2]  = '{1'b1, 16'hA5A7, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 16'hA5A6};
    vecs[3]  = '{1'b0, 16'h0000, 4'b0000, 4'b1111, 1'b1, 4'b1111, 1'b1, 16'hA5A7};
    // Partial stall: mask 1011, branch 3 stalls two cycles; zero-mask word
    // accepted in the cycle branch 3 finally handshakes.
    vecs[4]  = '{1'b1, 16'hBEEF, 4'b1011, 4'b0011, 1'b1, 4'b0000, 1'b0, 16'hA5A7};
    vecs[5]  = '{1'b1, 16'hCAFE, 4'b0000, 4'b0011, 1'b0, 4'b1011, 1'b1, 16'hBEEF};
    vecs[6]  = '{1'b1, 16'hCAFE, 4'b0000, 4'b0011, 1'b0, 4'b1000, 1'b1, 16'hBEEF};
    vecs[7]  = '{1'b1, 16'hCAFE, 4'b0000, 4'b1011, 1'b1, 4'b1000, 1'b1, 16'hBEEF};
    vecs[8]  = '{1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'hCAFE};
    // Zero mask from idle: accepted, dropped, data register still updates.
    vecs[9]  = '{1'b1, 16'h1234, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'hCAFE};
    vecs[10] = '{1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h1234};
    // Overlap: final delivery of word 1 on branch 2 coincides with accept of word 2.
    vecs[11] = '{1'b1, 16'h0001, 4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h1234};
    vecs[12] = '{1'b1, 16'h0002, 4'b0001, 4'b1011, 1'b0, 4'b0100, 1'b1, 16'h0001};
    vecs[13] = '{1'b1, 16'h0002, 4'b0001, 4'b0100, 1'b1, 4'b0100, 1'b1, 16'h0001};
    vecs[14] = '{1'b0, 16'h0000, 4'b0000, 4'b0100, 1'b0, 4'b0001, 1'b1, 16'h0002};
    vecs[15] = '{1'b0, 16'h0000, 4'b0000, 4'b0001, 1'b1, 4'b0001, 1'b1, 16'h0002};
    vecs[16] = '{1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0002};

    // Reset and release with in_valid low.
    reset_ = 1'b0;
    drive(1'b0, 16'h0000, 4'b0000, 4'b0000);
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    #1;
    check_outs("reset_release", 1'b1, 4'b0000, 1'b0, 16'h0000);

    // Table: drive at the falling edge, sample 1 time unit later, well clear of
    // the rising edge that consumes the inputs.
    for (int v = 0; v < NVEC; v++) begin
      @(negedge clk);
      drive(vecs[v].iv, vecs[v].d, vecs[v].m, vecs[v].r);
      #1;
      check_outs($sformatf("vec%0d", v), vecs[v].e_rdy, vecs[v].e_vld,
                 vecs[v].e_busy, vecs[v].e_data);
    end

    // Mid-transaction asynchronous reset.
    @(negedge clk);
    drive(1'b1, 16'hDEAD, 4'b1111, 4'b0000);
    @(negedge clk);
    drive(1'b0, 16'h0000, 4'b0000, 4'b0000);
    #1;
    check_outs("pre_reset", 1'b0, 4'b1111, 1'b1, 16'hDEAD);
    #1;
    reset_ = 1'b0;
    #1;
    // Still before the next rising edge: the async clear must already show.
    check_outs("async_reset", 1'b1, 4'b0000, 1'b0, 16'h0000);
    @(negedge clk);
    reset_ = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check_outs("post_reset", 1'b1, 4'b0000, 1'b0, 16'h0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_bcast_fork
